lane_frame_packer: RTL and testbench
====================================

// Module: lane_frame_packer
// PURPOSE
//  Upstream feeder for the cmmo consumer stage. Collects a stream of SYM_W-bit symbols into one
//  packed frame y[0:N_ROWS-1][0:N_COLS-1][SYM_W-1:0] plus a sequence tag sra[4:2][4:3].
//  Presents each frame to the consumer with a valid/ready handshake. Holds exactly one frame.
// PARAMETERS
//  SYM_W    2     bits per symbol (y innermost dimension)
//  N_ROWS   2     frame rows (y outer dimension)
//  N_COLS   4     symbols per row (y middle dimension)
//  PAD_SYM  2'b00 fill value for slots left empty by an early in_last
// PORTS
//  clk        in   1                      single clock, rising edge
//  rst        in   1                      synchronous reset, active-high
//  in_data    in   SYM_W                  input symbol
//  in_valid   in   1                      in_data valid
//  in_last    in   1                      symbol closes frame early (qualified by in_valid)
//  in_ready   out  1                      packer accepts symbol this cycle
//  y          out  N_ROWS*N_COLS*SYM_W    packed frame [0:N_ROWS-1][0:N_COLS-1][SYM_W-1:0]
//  sra        out  6                      [4:2][4:3]; {seq[3:0], padded, xz_seen}
//  out_valid  out  1                      frame on y/sra valid
//  out_ready  in   1                      consumer takes frame
// BEHAVIOUR
//  Slot order: symbol k (0-based in frame) -> y[k/N_COLS][k%N_COLS]; NSYM = N_ROWS*N_COLS = 8.
//  States: FILL (collecting, idx 0..NSYM-1), HOLD (frame presented).
//  FILL: in_ready=1. On in_valid, write slot idx and increment idx.
//   If idx==NSYM-1 or in_last: go to HOLD next cycle, out_valid=1, idx<=0.
//   On early in_last, pad slots idx+1..NSYM-1 with PAD_SYM and set padded=1.
//   in_last on the 8th symbol closes the frame normally; padded=0.
//  HOLD: y/sra stable while out_valid && !out_ready.
//   in_ready = out_ready (pass-through). On out_ready, seq increments mod 16.
//   If in_valid is also high in that cycle, the symbol is written to slot 0 of the next frame,
//   and the state is FILL with idx=1. A single-symbol frame with in_last returns to HOLD.
//   Otherwise the state goes to FILL with idx=0.
//  Zero-bubble: a new frame may present one cycle after the last symbol of the previous one.
//  Latency: last symbol accepted at edge N -> out_valid high after edge N.
//  out_valid never drops without out_ready.
//  Partial frame in FILL with in_valid=0: retained indefinitely. No timeout.
//  Reset (any state, mid-frame included): state=FILL, idx=0, seq=0, out_valid=0,
//   y all zero, sra=6'b0. Partial frame discarded. in_ready=1 from the first cycle after reset.
//  sra packing: sra[4]={seq[3],seq[2]}, sra[3]={seq[1],seq[0]}, sra[2]={padded,xz_seen}.
//  xz_seen=0 whenever the macro is absent.
// CONFIGURATION
//  `LANE_FRAME_XZ_SCRUB_EN defined:
//   Any X/Z bit in an accepted in_data is stored as 0, detected with ^in_data===1'bx.
//   xz_seen is set for the frame and cleared at the start of the next frame.
//  Undefined: in_data is stored verbatim (4-state propagates into y); xz_seen tied 0.
// STRUCTURE
//  Package lane_frame_pkg:
//   typedef logic [SYM_W-1:0] sym_t
//   typedef sym_t [0:N_ROWS-1][0:N_COLS-1] frame_t
//   typedef enum logic {FILL, HOLD} pk_state_e
//   typedef struct packed {logic [3:0] seq; logic padded; logic xz_seen;} tag_t
//   localparam NSYM
//  One sub-module, lane_frame_slot_wr: combinational slot decode and pad-mask generation
//   from idx/in_last. The FSM and registers stay in the top.
// TESTING
//  1) Reset, send syms 0,1,2,3,0,1,2,3 back-to-back, out_ready=1
//     -> y=16'h1B1B (y[0][0]=0..y[1][3]=3), sra=6'b000000, out_valid 1 cycle.
//  2) 3 syms 3,3,3 with in_last on 3rd
//     -> y[0][0:2]=3, rest PAD_SYM, sra[2]=2'b10; seq field = 1 if following test 1.
//  3) Hold out_ready=0 for 5 cycles while in_valid=1
//     -> y/sra stable, in_ready=0, no symbol lost once out_ready rises; next frame slot0 correct.
//  4) Continuous stream of 17 frames
//     -> seq wraps 15->0, one frame every 8 cycles, no bubble.
//  5) Assert rst after 5 symbols
//     -> out_valid=0, y=0, sra=0; next 8 symbols form a clean frame with seq=0.
//  6) With `LANE_FRAME_XZ_SCRUB_EN, in_data=2'bx1 in slot 2
//     -> y[0][2]=2'b01, xz_seen=1. Without the macro: y[0][2]=2'bx1, xz_seen=0.

Source files
------------

// File: rtl/lane_frame_pkg.sv
// Shared types and geometry for the lane frame packer.
// Optional X/Z scrubbing is enabled by defining LANE_FRAME_XZ_SCRUB_EN.
package lane_frame_pkg;

  localparam int unsigned SYM_W  = 2;
  localparam int unsigned N_ROWS = 2;
  localparam int unsigned N_COLS = 4;
  localparam int unsigned NSYM   = N_ROWS * N_COLS;
  localparam int unsigned IDX_W  = $clog2(NSYM);

  typedef logic [SYM_W-1:0] sym_t;
  typedef sym_t [0:N_ROWS-1][0:N_COLS-1] frame_t;

  typedef enum logic {FILL, HOLD} pk_state_e;

  typedef struct packed {
    logic [3:0] seq;
    logic       padded;
    logic       xz_seen;
  } tag_t;

  localparam sym_t PAD_SYM_DEF = '0;

endpackage

// File: rtl/lane_frame_slot_wr.sv
// Combinational slot decode: one-hot write mask for the current index and the
// pad mask covering the slots an early in_last leaves empty.
module lane_frame_slot_wr
  import lane_frame_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  input  logic             wr_en,
  input  logic             last,
  output logic [NSYM-1:0]  wr_mask,
  output logic [NSYM-1:0]  pad_mask,
  output logic             close,
  output logic             early
);

  always_comb begin
    wr_mask  = '0;
    pad_mask = '0;
    close    = wr_en && (last || (idx == IDX_W'(NSYM - 1)));
    early    = wr_en && last && (idx != IDX_W'(NSYM - 1));
    for (int unsigned k = 0; k < NSYM; k++) begin
      wr_mask[k]  = wr_en && (idx == IDX_W'(k));
      pad_mask[k] = early && (IDX_W'(k) > idx);
    end
  end

endmodule

// File: rtl/lane_frame_packer.sv
// Packs a symbol stream into one frame plus sequence tag, presented with valid/ready.
// Define LANE_FRAME_XZ_SCRUB_EN to zero X/Z input bits and flag them in xz_seen.
module lane_frame_packer
  import lane_frame_pkg::*;
#(
  parameter sym_t PAD_SYM = PAD_SYM_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  sym_t           in_data,
  input  logic           in_valid,
  input  logic           in_last,
  output logic           in_ready,
  output frame_t         y,
  output logic [4:2][4:3] sra,
  output logic           out_valid,
  input  logic           out_ready
);

  pk_state_e        state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  frame_t           frame_q;
  tag_t             tag_q;

  sym_t             sym_w;
  logic             sym_xz;
  logic             accept, take, close, early;
  logic [NSYM-1:0]  wr_mask, pad_mask;

  assign out_valid = (state_q == HOLD);
  assign in_ready  = (state_q == FILL) || out_ready;
  assign take      = out_valid && out_ready;
  assign accept    = in_valid && in_ready;

`ifdef LANE_FRAME_XZ_SCRUB_EN
  always_comb begin
    sym_w  = in_data;
    sym_xz = 1'b0;
    if ((^in_data) === 1'bx) begin
      sym_xz = 1'b1;
      for (int unsigned b = 0; b < SYM_W; b++) begin
        sym_w[b] = (in_data[b] === 1'b1) ? 1'b1 : 1'b0;
      end
    end
  end
`else
  assign sym_w  = in_data;
  assign sym_xz = 1'b0;
`endif

  // idx_q is always 0 in HOLD, so a symbol taken during handoff lands in slot 0.
  lane_frame_slot_wr u_slot_wr (
    .idx      (idx_q),
    .wr_en    (accept),
    .last     (in_last),
    .wr_mask  (wr_mask),
    .pad_mask (pad_mask),
    .close    (close),
    .early    (early)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= FILL;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL: if (close) state_d = HOLD;
      HOLD: if (take)  state_d = close ? HOLD : FILL;
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= '0;
      frame_q <= '0;
      tag_q   <= '0;
    end else begin
      if (take) tag_q.seq <= tag_q.seq + 4'd1;
      if (accept) begin
        idx_q          <= close ? '0 : idx_q + IDX_W'(1);
        tag_q.padded   <= early;
        tag_q.xz_seen  <= (idx_q == '0) ? sym_xz : (tag_q.xz_seen | sym_xz);
      end
      for (int unsigned k = 0; k < NSYM; k++) begin
        if (wr_mask[k])       frame_q[k / N_COLS][k % N_COLS] <= sym_w;
        else if (pad_mask[k]) frame_q[k / N_COLS][k % N_COLS] <= PAD_SYM;
      end
    end
  end

  assign y   = frame_q;
  assign sra = tag_q;

endmodule

// File: tb/tb_lane_frame_packer.sv
// Scoreboard bench for lane_frame_packer: a reference model pushes expected frames
// as symbols are accepted; a negedge monitor pops and compares on each handshake.
module tb_lane_frame_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  in_data;
  logic        in_valid, in_last, in_ready;
  logic [15:0] y;
  logic [5:0]  sra;
  logic        out_valid, out_ready;

  always #5 clk = ~clk;

  lane_frame_packer dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .y         (y),
    .sra       (sra),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] y;
    logic [15:0] ym;
    logic [5:0]  s;
    logic [5:0]  sm;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  logic [15:0] mf, mmask;
  int          mi, mseq;
  bit          mxz;
  int          last_pop = -1;
  bit          gap_chk  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mf = '0; mmask = '1; mi = 0; mseq = 0; mxz = 1'b0;
    sbq.delete();
  endtask

  task automatic model_accept(input logic [1:0] d, input logic l, input bit xm);
    exp_t  e;
    logic  pad;
    mf[15-2*mi -: 2] = d;
    if (xm) begin
      mmask[15-2*mi] = 1'b0;
      mxz = 1'b1;
    end
    if (l || mi == 7) begin
      pad = (mi < 7);
      for (int j = mi + 1; j < 8; j++) mf[15-2*j -: 2] = 2'b00;
      e.y  = mf;
      e.ym = mmask;
      e.s  = {mseq[3:0], pad, 1'b0};
`ifdef LANE_FRAME_XZ_SCRUB_EN
      e.sm = mxz ? 6'h3E : 6'h3F;
`else
      e.sm = 6'h3F;
`endif
      sbq.push_back(e);
      mseq  = (mseq + 1) % 16;
      mi    = 0;
      mmask = '1;
      mxz   = 1'b0;
    end else begin
      mi++;
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        check("unexpected_frame", sbq.size(), 1);
      end else begin
        mon_e = sbq.pop_front();
        check("frame_y", y & mon_e.ym, mon_e.y & mon_e.ym);
        check("frame_sra", sra & mon_e.sm, mon_e.s & mon_e.sm);
        if (gap_chk && last_pop >= 0) check("frame_gap", cyc - last_pop, 8);
        last_pop = cyc;
      end
    end
  end

  task automatic send_x(input logic [1:0] d, input logic l, input bit xm, output int tries);
    bit ok, rdy;
    in_valid = 1'b1; in_data = d; in_last = l;
    ok = 1'b0; tries = 0;
    for (int t = 0; t < 40 && !ok; t++) begin
      @(negedge clk);
      rdy = in_ready;
      tries++;
      @(posedge clk);
      if (rdy) begin
        model_accept(d, l, xm);
        ok = 1'b1;
      end
      #1;
    end
    if (!ok) check("send_timeout", 0, 1);
  endtask

  task automatic send(input logic [1:0] d, input logic l);
    int t;
    send_x(d, l, 1'b0, t);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0; in_last = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int tries;
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_y", y, 0);
    check("rst_sra", sra, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // 1: full frame, no in_last, one-cycle presentation
    for (int i = 0; i < 8; i++) send(2'(i % 4), 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t1_one_cycle", out_valid, 0);
    @(posedge clk); #1;

    // in_last on 8th symbol is a normal close
    for (int i = 0; i < 8; i++) send(2'(3 - (i % 4)), 1'(i == 7));
    idle(2);

    // 2: early close after three symbols
    send(2'd3, 1'b0); send(2'd3, 1'b0); send(2'd3, 1'b1);
    idle(2);

    // single-symbol frames taken during handoff
    for (int i = 0; i < 8; i++) send(2'(i % 3), 1'b0);
    send(2'd1, 1'b1);
    send(2'd2, 1'b1);
    idle(3);

    // 3: consumer stall with a symbol waiting
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(2'((i * 3) % 4), 1'b0);
    in_valid = 1'b1; in_data = 2'd2; in_last = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("stall_out_valid", out_valid, 1);
      check("stall_in_ready", in_ready, 0);
      check("stall_y", y, sbq[0].y);
      check("stall_sra", sra, sbq[0].s);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    model_accept(2'd2, 1'b0, 1'b0);
    #1;
    for (int i = 1; i < 8; i++) send(2'(i % 4), 1'b0);
    idle(3);

    // 4: 17 back-to-back frames, seq wraps, no bubbles
    gap_chk = 1'b1; last_pop = -1;
    for (int f = 0; f < 17; f++) begin
      for (int i = 0; i < 8; i++) begin
        send_x(2'($urandom_range(0, 3)), 1'b0, 1'b0, tries);
        check("no_bubble", tries, 1);
      end
    end
    idle(3);
    gap_chk = 1'b0;

    // 5: reset mid-frame
    for (int i = 0; i < 5; i++) send(2'd1, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_y", y, 0);
    check("midrst_sra", sra, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) send(2'(3 - (i % 4)), 1'b0);
    idle(2);

    // 6: X in slot 2
    send(2'd0, 1'b0); send(2'd1, 1'b0);
    send_x(2'bx1, 1'b0, 1'b1, tries);
    for (int i = 3; i < 8; i++) send(2'(i % 4), 1'b0);
    idle(2);

    for (int t = 0; t < 50 && sbq.size() != 0; t++) @(posedge clk);
    check("drain", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
